// File: rtl/svc_soc_io_arb_if.sv
// Bus bundle between two MMIO requesters, the arbiter and the LED/GPIO register bank.
// slave is the arbiter's view; master is the view of everything around it.
interface svc_soc_io_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic            req0_write;
    logic [AW-1:0]   req0_addr;
    logic [DW-1:0]   req0_wdata;
    logic [DW/8-1:0] req0_wstrb;
    logic            req0_resp_valid;
    logic            req0_resp_ready;
    logic [DW-1:0]   req0_resp_rdata;

    logic            req1_valid;
    logic            req1_ready;
    logic            req1_write;
    logic [AW-1:0]   req1_addr;
    logic [DW-1:0]   req1_wdata;
    logic [DW/8-1:0] req1_wstrb;
    logic            req1_resp_valid;
    logic            req1_resp_ready;
    logic [DW-1:0]   req1_resp_rdata;

    logic            io_wen;
    logic [AW-1:0]   io_waddr;
    logic [DW-1:0]   io_wdata;
    logic [DW/8-1:0] io_wstrb;
    logic            io_ren;
    logic [AW-1:0]   io_raddr;
    logic [DW-1:0]   io_rdata;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata, req0_wstrb, req0_resp_ready,
        output req0_ready, req0_resp_valid, req0_resp_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata, req1_wstrb, req1_resp_ready,
        output req1_ready, req1_resp_valid, req1_resp_rdata,
        output io_wen, io_waddr, io_wdata, io_wstrb, io_ren, io_raddr,
        input  io_rdata
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata, req0_wstrb, req0_resp_ready,
        input  req0_ready, req0_resp_valid, req0_resp_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata, req1_wstrb, req1_resp_ready,
        input  req1_ready, req1_resp_valid, req1_resp_rdata,
        input  io_wen, io_waddr, io_wdata, io_wstrb, io_ren, io_raddr,
        output io_rdata
    );
endinterface

// File: rtl/svc_soc_io_arb.sv
// Round-robin two-port arbiter/sequencer for the MMIO register bank: each granted
// request becomes a single-cycle wen/ren strobe followed by a buffered valid/ready response.
module svc_soc_io_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic                clk,
    input logic                rst_n,
    svc_soc_io_arb_if.slave    bus
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            owner_q, owner_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic grant;
    logic ready0;
    logic ready1;
    logic resp_hs;

    // Contention goes to whoever was not served last; last_grant resets to 1 so req0 wins first.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign ready0  = rst_n && (state_q == IDLE) && !grant && bus.req0_valid;
    assign ready1  = rst_n && (state_q == IDLE) &&  grant && bus.req1_valid;
    assign resp_hs = owner_q ? bus.req1_resp_ready : bus.req0_resp_ready;

    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (ready0 || ready1) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    write_d      = grant ? bus.req1_write : bus.req0_write;
                    addr_d       = grant ? bus.req1_addr  : bus.req0_addr;
                    wdata_d      = grant ? bus.req1_wdata : bus.req0_wdata;
                    wstrb_d      = grant ? bus.req1_wstrb : bus.req0_wstrb;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                rdata_d = write_q ? '0 : bus.io_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.req0_ready      = ready0;
    assign bus.req1_ready      = ready1;

    assign bus.io_wen          = (state_q == ISSUE) &&  write_q;
    assign bus.io_ren          = (state_q == ISSUE) && !write_q;
    assign bus.io_waddr        = addr_q;
    assign bus.io_raddr        = addr_q;
    assign bus.io_wdata        = wdata_q;
    assign bus.io_wstrb        = wstrb_q;

    assign bus.req0_resp_valid = (state_q == RESP) && !owner_q;
    assign bus.req1_resp_valid = (state_q == RESP) &&  owner_q;
    assign bus.req0_resp_rdata = bus.req0_resp_valid ? rdata_q : '0;
    assign bus.req1_resp_rdata = bus.req1_resp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_svc_soc_io_arb.sv
// Directed bench for svc_soc_io_arb: a per-cycle vector table plus hand-written
// sequences for asynchronous reset in ISSUE and RESP.
module tb_svc_soc_io_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] A = 32'h8000_0004;

    logic clk;
    logic rst_n;

    svc_soc_io_arb_if #(.AW(AW), .DW(DW)) bus ();

    svc_soc_io_arb #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle, then the outputs expected when sampled mid-cycle.
    typedef struct {
        logic [31:0] v0, w0, a0, d0, s0, rr0;
        logic [31:0] v1, w1, a1, d1, s1, rr1;
        logic [31:0] rd;
        logic [31:0] e_rdy0, e_rdy1, e_wen, e_ren, e_addr, e_wdata, e_wstrb;
        logic [31:0] e_rv0, e_rv1, e_rd0, e_rd1;
    } vec_t;

    vec_t vecs [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(
        input logic [31:0] v0, w0, a0, d0, s0, rr0,
        input logic [31:0] v1, w1, a1, d1, s1, rr1,
        input logic [31:0] rd,
        input logic [31:0] e_rdy0, e_rdy1, e_wen, e_ren, e_addr, e_wdata, e_wstrb,
        input logic [31:0] e_rv0, e_rv1, e_rd0, e_rd1
    );
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.s0 = s0; v.rr0 = rr0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.s1 = s1; v.rr1 = rr1;
        v.rd = rd;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_wen = e_wen; v.e_ren = e_ren;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
        v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.req0_valid      = v.v0[0];
        bus.req0_write      = v.w0[0];
        bus.req0_addr       = v.a0;
        bus.req0_wdata      = v.d0;
        bus.req0_wstrb      = v.s0[3:0];
        bus.req0_resp_ready = v.rr0[0];
        bus.req1_valid      = v.v1[0];
        bus.req1_write      = v.w1[0];
        bus.req1_addr       = v.a1;
        bus.req1_wdata      = v.d1;
        bus.req1_wstrb      = v.s1[3:0];
        bus.req1_resp_ready = v.rr1[0];
        bus.io_rdata        = v.rd;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, ".req0_ready"},      32'(bus.req0_ready),      v.e_rdy0);
        check({tag, ".req1_ready"},      32'(bus.req1_ready),      v.e_rdy1);
        check({tag, ".io_wen"},          32'(bus.io_wen),          v.e_wen);
        check({tag, ".io_ren"},          32'(bus.io_ren),          v.e_ren);
        check({tag, ".io_waddr"},        bus.io_waddr,             v.e_addr);
        check({tag, ".io_raddr"},        bus.io_raddr,             v.e_addr);
        check({tag, ".io_wdata"},        bus.io_wdata,             v.e_wdata);
        check({tag, ".io_wstrb"},        32'(bus.io_wstrb),        v.e_wstrb);
        check({tag, ".req0_resp_valid"}, 32'(bus.req0_resp_valid), v.e_rv0);
        check({tag, ".req1_resp_valid"}, 32'(bus.req1_resp_valid), v.e_rv1);
        check({tag, ".req0_resp_rdata"}, bus.req0_resp_rdata,     v.e_rd0);
        check({tag, ".req1_resp_rdata"}, bus.req1_resp_rdata,     v.e_rd1);
    endtask

    initial begin
        vec_t z;
        logic [31:0] pa, pw, ps;

        // Inputs: v0,w0,a0,d0,s0,rr0, v1,w1,a1,d1,s1,rr1, io_rdata
        // Expect: rdy0,rdy1,wen,ren,addr,wdata,wstrb, rv0,rv1,rd0,rd1
        // req0 write, then req1 read of the same address.
        add(1,1,A,'hA5,'hF,1, 0,0,0,0,0,1, 0,     1,0,0,0,0,0,0,      0,0,0,0);
        add(0,0,0,0,0,1,      0,0,0,0,0,1, 0,     0,0,1,0,A,'hA5,'hF, 0,0,0,0);
        add(0,0,0,0,0,1,      0,0,0,0,0,1, 0,     0,0,0,0,A,'hA5,'hF, 1,0,0,0);
        add(0,0,0,0,0,1,      1,0,A,0,0,1, 0,     0,1,0,0,A,'hA5,'hF, 0,0,0,0);
        add(0,0,0,0,0,1,      0,0,0,0,0,1, 'hA5,  0,0,0,1,A,0,0,      0,0,0,0);
        add(0,0,0,0,0,1,      0,0,0,0,0,1, 0,     0,0,0,0,A,0,0,      0,1,0,'hA5);
        // Both requesters continuously valid: grants alternate 0,1,0,1.
        for (int k = 0; k < 2; k++) begin
            pa = (k == 0) ? A : 32'h20;
            pw = (k == 0) ? 32'h0 : 32'h22;
            ps = 32'h0;
            add(1,1,'h10,'h11,3,1, 1,0,'h20,'h22,0,1, 'h55,  1,0,0,0,pa,pw,ps,        0,0,0,0);
            add(1,1,'h10,'h11,3,1, 1,0,'h20,'h22,0,1, 'h55,  0,0,1,0,'h10,'h11,3,     0,0,0,0);
            add(1,1,'h10,'h11,3,1, 1,0,'h20,'h22,0,1, 'h55,  0,0,0,0,'h10,'h11,3,     1,0,0,0);
            add(1,1,'h10,'h11,3,1, 1,0,'h20,'h22,0,1, 'h55,  0,1,0,0,'h10,'h11,3,     0,0,0,0);
            add(1,1,'h10,'h11,3,1, 1,0,'h20,'h22,0,1, 'h55,  0,0,0,1,'h20,'h22,0,     0,0,0,0);
            add(1,1,'h10,'h11,3,1, 1,0,'h20,'h22,0,1, 'h55,  0,0,0,0,'h20,'h22,0,     0,1,0,'h55);
        end
        // req0 read, response stalled 5 cycles while both keep valid high.
        add(1,0,'h30,0,0,0, 1,0,'h20,'h22,0,1, 'h77,  1,0,0,0,'h20,'h22,0,  0,0,0,0);
        add(1,0,'h30,0,0,0, 1,0,'h20,'h22,0,1, 'h77,  0,0,0,1,'h30,0,0,     0,0,0,0);
        for (int k = 0; k < 5; k++)
            add(1,0,'h30,0,0,0, 1,0,'h20,'h22,0,1, 'h99,  0,0,0,0,'h30,0,0,  1,0,'h77,0);
        add(0,0,0,0,0,1,      1,0,'h20,'h22,0,1, 'h99,  0,0,0,0,'h30,0,0,     1,0,'h77,0);
        add(0,0,0,0,0,1,      1,0,'h20,'h22,0,1, 'h99,  0,1,0,0,'h30,0,0,     0,0,0,0);
        add(0,0,0,0,0,1,      0,0,0,0,0,1,       'h99,  0,0,0,1,'h20,'h22,0,  0,0,0,0);
        add(0,0,0,0,0,1,      0,0,0,0,0,1,       0,     0,0,0,0,'h20,'h22,0,  0,1,0,'h99);
        // Quiet bus.
        for (int k = 0; k < 10; k++)
            add(0,0,0,0,0,1,  0,0,0,0,0,1,       0,     0,0,0,0,'h20,'h22,0,  0,0,0,0);

        // Reset with both requesters asserting valid: every output must be 0.
        z = vecs[0];
        z.v0 = 1; z.v1 = 1;
        rst_n = 1'b0;
        drive(z);
        #12;
        z.e_rdy0 = 0; z.e_rdy1 = 0; z.e_wen = 0; z.e_ren = 0; z.e_addr = 0;
        z.e_wdata = 0; z.e_wstrb = 0; z.e_rv0 = 0; z.e_rv1 = 0; z.e_rd0 = 0; z.e_rd1 = 0;
        check_vec("reset", z);
        z.v0 = 0; z.v1 = 0;
        drive(z);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check_vec($sformatf("v%0d", i), vecs[i]);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while a write is in ISSUE.
        z = vecs[$];
        z.v0 = 1; z.w0 = 1; z.a0 = 'h40; z.d0 = 'h41; z.s0 = 'hF;
        drive(z);
        @(posedge clk);
        #1;
        z.v0 = 0;
        drive(z);
        #2;
        check("issue.io_wen_before_reset", 32'(bus.io_wen), 32'h1);
        rst_n = 1'b0;
        #1;
        check("issue_rst.io_wen",   32'(bus.io_wen),   32'h0);
        check("issue_rst.io_ren",   32'(bus.io_ren),   32'h0);
        check("issue_rst.io_waddr", bus.io_waddr,      32'h0);
        check("issue_rst.io_wdata", bus.io_wdata,      32'h0);
        check("issue_rst.io_wstrb", 32'(bus.io_wstrb), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d.io_wen", k),          32'(bus.io_wen),          32'h0);
            check($sformatf("post_rst%0d.io_ren", k),          32'(bus.io_ren),          32'h0);
            check($sformatf("post_rst%0d.req0_resp_valid", k), 32'(bus.req0_resp_valid), 32'h0);
        end

        // Asynchronous reset while a read response is held in RESP.
        @(posedge clk);
        #1;
        z.v1 = 1; z.w1 = 0; z.a1 = 'h44; z.rr1 = 0; z.rd = 'h66;
        drive(z);
        @(posedge clk);
        #1;
        z.v1 = 0;
        drive(z);
        @(posedge clk);
        #1;
        check("resp.req1_resp_valid_before_reset", 32'(bus.req1_resp_valid), 32'h1);
        check("resp.req1_resp_rdata_before_reset", bus.req1_resp_rdata,      32'h66);
        rst_n = 1'b0;
        #1;
        check("resp_rst.req1_resp_valid", 32'(bus.req1_resp_valid), 32'h0);
        check("resp_rst.req1_resp_rdata", bus.req1_resp_rdata,      32'h0);
        check("resp_rst.io_raddr",        bus.io_raddr,             32'h0);
        z.v0 = 1; z.w0 = 0; z.a0 = 'h50; z.v1 = 1; z.a1 = 'h60; z.rr0 = 1; z.rr1 = 1;
        drive(z);
        #1;
        check("resp_rst.req0_ready", 32'(bus.req0_ready), 32'h0);
        check("resp_rst.req1_ready", 32'(bus.req1_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel.req0_ready", 32'(bus.req0_ready), 32'h1);
        check("rel.req1_ready", 32'(bus.req1_ready), 32'h0);
        @(posedge clk);
        #1;
        z.v0 = 0; z.v1 = 0;
        drive(z);
        check("rel.io_ren",   32'(bus.io_ren), 32'h1);
        check("rel.io_raddr", bus.io_raddr,    32'h50);
        @(posedge clk);
        #1;
        check("rel.req0_resp_valid", 32'(bus.req0_resp_valid), 32'h1);
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
